miner_work_loader: RTL and testbench
====================================

Name: miner_work_loader

Overview:
- Receiving end of the host-to-miner work path. Accepts an 80-byte Bitcoin block header as a byte stream in wire order (little-endian per field).
- Checks frame length and splits the header into fields: version, prev_block, merkle_root, timestamp, target bits, starting nonce.
- Presents the fields to the miner/prenonce stage through a valid/ready work handshake.
- Holds one frame being assembled plus one frame presented, so the host can stream the next header while the miner holds the current one.

Parameters:
- HEADER_BYTES, 80, frame length in bytes; only 80 is legal (elaboration assertion otherwise).
- DRAIN_ON_OVERRUN, 1, 1: on an over-long frame, discard bytes until rx_last; 0: resynchronise immediately after byte 79.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- rx_data  in  8  header byte
- rx_valid  in  1  byte valid
- rx_last  in  1  marks final byte of frame
- rx_ready  out  1  loader accepts byte
- work_valid  out  1  work fields valid
- work_ready  in  1  miner takes work
- version  out  32  header version
- prev_block  out  [7:0][31:0]  previous block hash, word 0 = first 4 wire bytes
- merkle_root  out  [7:0][31:0]  merkle root, same word order
- timestamp  out  32  header time
- target_bits  out  32  header bits
- nonce_start  out  32  nonce from header
- err_short  out  1  one-cycle pulse, frame ended before 80 bytes
- err_long  out  1  one-cycle pulse, byte 79 accepted without rx_last

Behaviour:
- A byte transfers on a clk edge where rx_valid && rx_ready.
- A byte counter (7 bits) indexes the shadow buffer. Each field word is assembled little-endian: word = {b[i+3], b[i+2], b[i+1], b[i]}.
- Field byte offsets:
  - version 0..3
  - prev_block[k] at 4+4k
  - merkle_root[k] at 36+4k
  - timestamp 68
  - target_bits 72
  - nonce_start 76
- States:
  - COLLECT: rx_ready=1; accept bytes into the shadow buffer.
    - rx_last at count 79 -> LOADED.
    - rx_last at count <79 -> err_short pulse, counter cleared, frame discarded, stay in COLLECT.
    - Byte 79 without rx_last -> err_long pulse; DRAIN if DRAIN_ON_OVERRUN, else COLLECT with counter 0.
  - DRAIN: rx_ready=1; discard bytes; on rx_last -> COLLECT, counter 0.
  - LOADED: rx_ready=0. Transfer shadow -> output registers when the output slot is empty, or is vacated on this edge (work_valid && work_ready). Then work_valid<=1, counter 0, -> COLLECT.
- work_valid: set on transfer, cleared on the work_valid && work_ready edge unless a new transfer happens on the same edge (then it stays 1 with the new fields).
- Output fields are stable while work_valid=1 and the miner has not taken them.
- Latency: last-byte edge N -> LOADED; edge N+1 -> work_valid=1 if the slot is free. Minimum gap between frames: 1 dead rx cycle.
- Simultaneous rx_last on byte 0: counts as a short frame (err_short).
- rx_valid low mid-frame: counter holds, no timeout.
- Reset (asynchronous, rst=0):
  - Outputs: work_valid=0, rx_ready=0 during reset, err_*=0, all fields 0.
  - State: COLLECT, counter 0.
  - rx_ready=1 from the first edge after deassertion.
  - Reset mid-frame loses the partial frame; the next accepted byte is byte 0.

Decomposition:
- miner_pkg holds:
  - HEADER_BYTES
  - field offset localparams (OFF_VERSION, OFF_PREV, OFF_MERKLE, OFF_TIME, OFF_BITS, OFF_NONCE)
  - typedef miner_work_t: packed struct of the six fields, reused by the prenonce/nonce stages
  - function le_word(bytes) for byte-to-word assembly
- One sub-module is natural: miner_hdr_shift, the 80x8 byte-addressed shadow buffer with write-enable by index.

Test Plan:
- Genesis-style frame, bytes 02 00 00 00, 17 97 5b 97 ... (prev 00000000_00000001_17c80378_..._975b9717, merkle 871714dc_..._5a29978a, time 53058b35, bits 19015f53, nonce 33087548), work_ready=1 -> exactly 2 cycles after the last byte: work_valid=1, version=00000002, prev_block[0]=975b9717, prev_block[7]=00000000, merkle_root[7]=871714dc, timestamp=53058b35, target_bits=19015f53, nonce_start=33087548.
- Two back-to-back frames with work_ready=0 -> first frame held stable; second frame reaches LOADED and rx_ready=0. Raise work_ready for 1 cycle -> second frame appears on the same edge and work_valid stays 1.
- 40-byte frame with rx_last -> err_short one pulse, no work_valid. Following good frame loads correctly.
- 85-byte frame, DRAIN_ON_OVERRUN=1 -> err_long at byte 79, bytes 80-84 discarded, no work_valid. Next good frame correct.
- rst asserted after byte 30 of a frame, released, full frame sent -> outputs 0 during reset; post-reset frame decodes correctly; no error pulses.
- Random rx_valid gaps (50%) and work_ready backpressure over 100 frames -> scoreboard matches every field; no frame lost or duplicated.

Source files
------------

// File: rtl/miner_pkg.sv
// Shared types and constants for the miner work path: header layout, field
// offsets within the 80-byte wire frame and the decoded work record.
`timescale 1ns/1ps
package miner_pkg;

    localparam int unsigned HEADER_BYTES = 80;

    localparam int unsigned OFF_VERSION = 0;
    localparam int unsigned OFF_PREV    = 4;
    localparam int unsigned OFF_MERKLE  = 36;
    localparam int unsigned OFF_TIME    = 68;
    localparam int unsigned OFF_BITS    = 72;
    localparam int unsigned OFF_NONCE   = 76;

    typedef struct packed {
        logic [31:0]      version;
        logic [7:0][31:0] prev_block;
        logic [7:0][31:0] merkle_root;
        logic [31:0]      timestamp;
        logic [31:0]      target_bits;
        logic [31:0]      nonce_start;
    } miner_work_t;

    typedef enum logic [1:0] {
        ST_COLLECT,
        ST_DRAIN,
        ST_LOADED
    } ldr_state_t;

    // b[0] is the first byte on the wire; the field is little-endian.
    function automatic logic [31:0] le_word(input logic [3:0][7:0] b);
        return {b[3], b[2], b[1], b[0]};
    endfunction

endpackage

// File: rtl/miner_hdr_shift.sv
// Byte-addressed shadow buffer holding the header frame under assembly.
`timescale 1ns/1ps
module miner_hdr_shift
    import miner_pkg::*;
(
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_wr_en,
    input  logic [6:0]                   i_wr_idx,
    input  logic [7:0]                   i_wr_data,
    output logic [HEADER_BYTES-1:0][7:0] o_bytes
);

    logic [HEADER_BYTES-1:0][7:0] r_bytes;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bytes <= '0;
        end else if (i_wr_en) begin
            r_bytes[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_bytes = r_bytes;

endmodule

// File: rtl/miner_work_loader.sv
// Host-to-miner header loader: checks frame length, splits the 80-byte header
// into fields and presents them through a one-deep valid/ready work slot.
`timescale 1ns/1ps
module miner_work_loader #(
    parameter int unsigned HEADER_BYTES     = miner_pkg::HEADER_BYTES,
    parameter bit          DRAIN_ON_OVERRUN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    input  logic             rx_last,
    output logic             rx_ready,
    output logic             work_valid,
    input  logic             work_ready,
    output logic [31:0]      version,
    output logic [7:0][31:0] prev_block,
    output logic [7:0][31:0] merkle_root,
    output logic [31:0]      timestamp,
    output logic [31:0]      target_bits,
    output logic [31:0]      nonce_start,
    output logic             err_short,
    output logic             err_long
);
    import miner_pkg::*;

    if (HEADER_BYTES != 80) begin : g_bad_header_bytes
        $error("miner_work_loader: HEADER_BYTES must be 80");
    end

    localparam logic [6:0] LAST_IDX = 7'(HEADER_BYTES - 1);

    ldr_state_t r_state, w_state_nxt;
    logic [6:0] r_cnt, w_cnt_nxt;
    logic       r_run;
    logic       r_err_short, r_err_long, w_err_short_nxt, w_err_long_nxt;
    logic       w_rx_fire, w_wr_en, w_load, w_take;
    logic       r_work_valid;
    miner_work_t r_work, w_hdr;
    logic [HEADER_BYTES-1:0][7:0] w_bytes;

    // r_run keeps rx_ready low through reset and releases it on the first edge after.
    assign rx_ready  = r_run && (r_state != ST_LOADED);
    assign w_rx_fire = rx_valid && rx_ready;
    assign w_wr_en   = w_rx_fire && (r_state == ST_COLLECT);
    assign w_take    = r_work_valid && work_ready;
    assign w_load    = (r_state == ST_LOADED) && (!r_work_valid || work_ready);

    miner_hdr_shift u_shift (
        .i_clk     (clk),
        .i_rst_n   (rst),
        .i_wr_en   (w_wr_en),
        .i_wr_idx  (r_cnt),
        .i_wr_data (rx_data),
        .o_bytes   (w_bytes)
    );

    always_comb begin
        w_hdr = '0;
        w_hdr.version = le_word(w_bytes[OFF_VERSION +: 4]);
        for (int unsigned k = 0; k < 8; k++) begin
            w_hdr.prev_block[k]  = le_word(w_bytes[OFF_PREV + 4*k +: 4]);
            w_hdr.merkle_root[k] = le_word(w_bytes[OFF_MERKLE + 4*k +: 4]);
        end
        w_hdr.timestamp   = le_word(w_bytes[OFF_TIME +: 4]);
        w_hdr.target_bits = le_word(w_bytes[OFF_BITS +: 4]);
        w_hdr.nonce_start = le_word(w_bytes[OFF_NONCE +: 4]);
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_err_short_nxt = 1'b0;
        w_err_long_nxt  = 1'b0;
        case (r_state)
            ST_COLLECT: begin
                if (w_rx_fire) begin
                    if (rx_last) begin
                        w_cnt_nxt = '0;
                        if (r_cnt == LAST_IDX) begin
                            w_state_nxt = ST_LOADED;
                        end else begin
                            w_err_short_nxt = 1'b1;
                        end
                    end else if (r_cnt == LAST_IDX) begin
                        w_cnt_nxt      = '0;
                        w_err_long_nxt = 1'b1;
                        w_state_nxt    = DRAIN_ON_OVERRUN ? ST_DRAIN : ST_COLLECT;
                    end else begin
                        w_cnt_nxt = r_cnt + 7'd1;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_rx_fire && rx_last) begin
                    w_state_nxt = ST_COLLECT;
                    w_cnt_nxt   = '0;
                end
            end
            ST_LOADED: begin
                if (w_load) begin
                    w_state_nxt = ST_COLLECT;
                end
            end
            default: begin
                w_state_nxt = ST_COLLECT;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_COLLECT;
            r_cnt       <= '0;
            r_run       <= 1'b0;
            r_err_short <= 1'b0;
            r_err_long  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_run       <= 1'b1;
            r_err_short <= w_err_short_nxt;
            r_err_long  <= w_err_long_nxt;
        end
    end

    // A load on the same edge as a take keeps work_valid high with the new fields.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_work       <= '0;
            r_work_valid <= 1'b0;
        end else if (w_load) begin
            r_work       <= w_hdr;
            r_work_valid <= 1'b1;
        end else if (w_take) begin
            r_work_valid <= 1'b0;
        end
    end

    assign work_valid  = r_work_valid;
    assign version     = r_work.version;
    assign prev_block  = r_work.prev_block;
    assign merkle_root = r_work.merkle_root;
    assign timestamp   = r_work.timestamp;
    assign target_bits = r_work.target_bits;
    assign nonce_start = r_work.nonce_start;
    assign err_short   = r_err_short;
    assign err_long    = r_err_long;

endmodule

// File: tb/tb_miner_work_loader.sv
// Directed and randomised checks of miner_work_loader framing, decode and handshake.
`timescale 1ns/1ps
module tb_miner_work_loader;
    import miner_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [7:0]       rx_data = '0;
    logic             rx_valid = 1'b0;
    logic             rx_last = 1'b0;
    logic             rx_ready;
    logic             work_valid;
    logic             work_ready = 1'b0;
    logic [31:0]      version;
    logic [7:0][31:0] prev_block;
    logic [7:0][31:0] merkle_root;
    logic [31:0]      timestamp;
    logic [31:0]      target_bits;
    logic [31:0]      nonce_start;
    logic             err_short;
    logic             err_long;

    miner_work_loader #(.HEADER_BYTES(80), .DRAIN_ON_OVERRUN(1'b1)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_last     (rx_last),
        .rx_ready    (rx_ready),
        .work_valid  (work_valid),
        .work_ready  (work_ready),
        .version     (version),
        .prev_block  (prev_block),
        .merkle_root (merkle_root),
        .timestamp   (timestamp),
        .target_bits (target_bits),
        .nonce_start (nonce_start),
        .err_short   (err_short),
        .err_long    (err_long)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned n_short  = 0;
    int unsigned n_long   = 0;

    always @(negedge clk) begin
        if (err_short) n_short++;
        if (err_long)  n_long++;
    end

    // Wire-order header words: the first byte on the wire is bits [31:24].
    logic [31:0] gen_w [20] = '{
        32'h02000000,
        32'h17975b97, 32'h11111111, 32'h22222222, 32'h33333333,
        32'h44444444, 32'h7803c817, 32'h01000000, 32'h00000000,
        32'h8a97295a, 32'ha1a1a1a1, 32'ha2a2a2a2, 32'ha3a3a3a3,
        32'ha4a4a4a4, 32'ha5a5a5a5, 32'ha6a6a6a6, 32'hdc141787,
        32'h358b0553, 32'h535f0119, 32'h48750833
    };

    miner_work_t sb [$];

    task automatic check_val(input string tag, input logic [639:0] obs, input logic [639:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] bswap(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    task automatic to_wire(input miner_work_t f, output logic [31:0] w [20]);
        w[0] = bswap(f.version);
        for (int k = 0; k < 8; k++) begin
            w[1+k] = bswap(f.prev_block[k]);
            w[9+k] = bswap(f.merkle_root[k]);
        end
        w[17] = bswap(f.timestamp);
        w[18] = bswap(f.target_bits);
        w[19] = bswap(f.nonce_start);
    endtask

    function automatic miner_work_t rand_work();
        miner_work_t f;
        f.version = $urandom;
        for (int k = 0; k < 8; k++) begin
            f.prev_block[k]  = $urandom;
            f.merkle_root[k] = $urandom;
        end
        f.timestamp   = $urandom;
        f.target_bits = $urandom;
        f.nonce_start = $urandom;
        return f;
    endfunction

    function automatic miner_work_t obs_work();
        miner_work_t f;
        f.version     = version;
        f.prev_block  = prev_block;
        f.merkle_root = merkle_root;
        f.timestamp   = timestamp;
        f.target_bits = target_bits;
        f.nonce_start = nonce_start;
        return f;
    endfunction

    // Returns #1 after the edge on which the byte transferred.
    task automatic send_byte(input logic [7:0] d, input logic last, input bit rnd);
        int unsigned waited;
        bit done;
        waited = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            rx_data  = d;
            rx_last  = last;
            rx_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rx_valid && rx_ready) begin
                done = 1'b1;
            end else if (++waited > 2000) begin
                check_val("rx_accept_timeout", 640'(rx_ready), 640'(1));
                done = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] w [20], input int unsigned first,
                              input int unsigned count, input bit last_flag, input bit rnd);
        for (int unsigned i = first; i < first + count; i++) begin
            logic [31:0] ww;
            logic [7:0]  d;
            if (i < 80) begin
                ww = w[i/4];
                d  = ww[31 - 8*(i%4) -: 8];
            end else begin
                d = 8'hee;
            end
            send_byte(d, last_flag && (i == first + count - 1), rnd);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        miner_work_t fa, fb, fc;
        logic [31:0] wa [20];
        logic [31:0] wb [20];
        int unsigned s0, l0, got, cyc;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_rx_ready",   640'(rx_ready), 640'(0));
        check_val("rst_work_valid", 640'(work_valid), 640'(0));
        check_val("rst_fields",     640'(obs_work()), 640'(0));
        check_val("rst_err",        640'({err_short, err_long}), 640'(0));
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        check_val("rx_ready_after_rst", 640'(rx_ready), 640'(1));

        // Genesis-style frame, latency and field decode
        work_ready = 1'b1;
        send_frame(gen_w, 0, 80, 1'b1, 1'b0);
        check_val("gen_wv_edge_n",   640'(work_valid), 640'(0));
        check_val("gen_rx_ready_ld", 640'(rx_ready), 640'(0));
        @(posedge clk);
        #1;
        check_val("gen_wv_edge_n1", 640'(work_valid), 640'(1));
        check_val("gen_version",    640'(version), 640'(32'h00000002));
        check_val("gen_prev0",      640'(prev_block[0]), 640'(32'h975b9717));
        check_val("gen_prev5",      640'(prev_block[5]), 640'(32'h17c80378));
        check_val("gen_prev6",      640'(prev_block[6]), 640'(32'h00000001));
        check_val("gen_prev7",      640'(prev_block[7]), 640'(32'h00000000));
        check_val("gen_merkle0",    640'(merkle_root[0]), 640'(32'h5a29978a));
        check_val("gen_merkle7",    640'(merkle_root[7]), 640'(32'h871714dc));
        check_val("gen_time",       640'(timestamp), 640'(32'h53058b35));
        check_val("gen_bits",       640'(target_bits), 640'(32'h19015f53));
        check_val("gen_nonce",      640'(nonce_start), 640'(32'h33087548));
        check_val("gen_rx_resume",  640'(rx_ready), 640'(1));
        @(posedge clk);
        #1;
        check_val("gen_taken", 640'(work_valid), 640'(0));
        work_ready = 1'b0;

        // Back-to-back frames under backpressure
        fa = rand_work();
        fb = rand_work();
        to_wire(fa, wa);
        to_wire(fb, wb);
        send_frame(wa, 0, 80, 1'b1, 1'b0);
        send_frame(wb, 0, 80, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_val("b2b_hold_valid", 640'(work_valid), 640'(1));
        check_val("b2b_hold_a",     640'(obs_work()), 640'(fa));
        check_val("b2b_rx_stall",   640'(rx_ready), 640'(0));
        @(negedge clk) work_ready = 1'b1;
        @(posedge clk);
        #1;
        work_ready = 1'b0;
        check_val("b2b_swap_valid", 640'(work_valid), 640'(1));
        check_val("b2b_swap_b",     640'(obs_work()), 640'(fb));
        check_val("b2b_rx_resume",  640'(rx_ready), 640'(1));
        @(negedge clk) work_ready = 1'b1;
        @(posedge clk);
        #1;
        work_ready = 1'b0;
        check_val("b2b_drained", 640'(work_valid), 640'(0));

        // Short frame, then a good one
        s0 = n_short;
        send_frame(gen_w, 0, 40, 1'b1, 1'b0);
        check_val("short_pulse", 640'(err_short), 640'(1));
        @(posedge clk);
        #1;
        check_val("short_pulse_end", 640'(err_short), 640'(0));
        repeat (2) @(posedge clk);
        #1;
        check_val("short_no_wv",    640'(work_valid), 640'(0));
        check_val("short_count",    640'(n_short - s0), 640'(1));
        fc = rand_work();
        to_wire(fc, wa);
        work_ready = 1'b1;
        send_frame(wa, 0, 80, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check_val("after_short_frame", 640'(obs_work()), 640'(fc));
        check_val("after_short_wv",    640'(work_valid), 640'(1));
        @(posedge clk);
        #1;

        // 85-byte frame drained, then a good one
        s0 = n_short;
        l0 = n_long;
        fc = rand_work();
        to_wire(fc, wa);
        send_frame(wa, 0, 80, 1'b0, 1'b0);
        check_val("long_pulse", 640'(err_long), 640'(1));
        send_frame(wa, 80, 5, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_val("long_no_wv",       640'(work_valid), 640'(0));
        check_val("long_count",       640'(n_long - l0), 640'(1));
        check_val("long_no_short",    640'(n_short - s0), 640'(0));
        send_frame(wa, 0, 80, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check_val("after_long_frame", 640'(obs_work()), 640'(fc));
        @(posedge clk);
        #1;
        work_ready = 1'b0;

        // Reset mid-frame
        fc = rand_work();
        to_wire(fc, wa);
        send_frame(gen_w, 0, 31, 1'b0, 1'b0);
        @(negedge clk) rst = 1'b0;
        #1;
        check_val("midrst_rx_ready", 640'(rx_ready), 640'(0));
        check_val("midrst_wv",       640'(work_valid), 640'(0));
        check_val("midrst_fields",   640'(obs_work()), 640'(0));
        @(negedge clk) rst = 1'b1;
        s0 = n_short;
        l0 = n_long;
        work_ready = 1'b1;
        send_frame(wa, 0, 80, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check_val("postrst_wv",     640'(work_valid), 640'(1));
        check_val("postrst_frame",  640'(obs_work()), 640'(fc));
        check_val("postrst_no_err", 640'((n_short - s0) + (n_long - l0)), 640'(0));
        @(posedge clk);
        #1;
        work_ready = 1'b0;

        // Random rx gaps and work_ready backpressure
        got = 0;
        cyc = 0;
        fork
            begin
                for (int n = 0; n < 100; n++) begin
                    miner_work_t fr;
                    logic [31:0] wr [20];
                    fr = rand_work();
                    to_wire(fr, wr);
                    sb.push_back(fr);
                    send_frame(wr, 0, 80, 1'b1, 1'b1);
                end
            end
            begin
                while (got < 100 && cyc < 60000) begin
                    @(negedge clk);
                    cyc++;
                    work_ready = 1'($urandom_range(0, 1));
                    if (work_valid && work_ready) begin
                        if (sb.size() == 0) begin
                            check_val("sb_underflow", 640'(sb.size()), 640'(1));
                        end else begin
                            check_val("sb_frame", 640'(obs_work()), 640'(sb.pop_front()));
                        end
                        got++;
                    end
                end
                work_ready = 1'b0;
            end
        join
        check_val("sb_count",    640'(got), 640'(100));
        check_val("sb_leftover", 640'(sb.size()), 640'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
